// File: rtl/cook_seq_pkg.sv
// Shared encodings and helpers for the microwave cook sequencer.
package cook_seq_pkg;
  localparam int MAX_DIGITS_DEF = 3;
  localparam int DIGIT_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic onehot10(input logic [9:0] v);
    return (v != 10'd0) && ((v & (v - 10'd1)) == 10'd0);
  endfunction

  function automatic logic [DIGIT_W-1:0] key_index(input logic [9:0] v);
    logic [DIGIT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 10; i++)
      if (v[i]) idx = DIGIT_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/cook_sequencer_press_detect.sv
// Registers one active-low button and emits a single-cycle pulse on its
// registered 1->0 edge; both history flops reset to "released".
module press_detect (
  input  logic clk,
  input  logic resetn,
  input  logic btn_n,
  output logic press
);
  logic btn_q, btn_d, prev_q, prev_d;

  always_comb begin
    btn_d  = btn_n;
    prev_d = btn_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      btn_q  <= btn_d;
      prev_q <= prev_d;
    end
  end

  assign press = prev_q & ~btn_q;
endmodule

// File: rtl/cook_sequencer.sv
// Microwave cook sequencer: keypad entry, cook/pause/done control.
// Optional done beep output when COOK_SEQ_BEEP_EN is defined.
module cook_sequencer
  import cook_seq_pkg::*;
#(
  parameter int MAX_DIGITS  = MAX_DIGITS_DEF,
  parameter int BEEP_CYCLES = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic [9:0]         keypad,
  input  logic               zero,
  output logic [DIGIT_W-1:0] data,
  output logic               load,
  output logic               timer_clear,
  output logic               timer_en,
  output logic               mag_on,
  output logic               done,
`ifdef COOK_SEQ_BEEP_EN
  output logic               beep,
`endif
  output logic [2:0]         state
);
  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic start_p, stop_p, clear_p;
  press_detect u_start (.clk(clk), .resetn(resetn), .btn_n(startn), .press(start_p));
  press_detect u_stop  (.clk(clk), .resetn(resetn), .btn_n(stopn),  .press(stop_p));
  press_detect u_clear (.clk(clk), .resetn(resetn), .btn_n(clearn), .press(clear_p));

  logic [9:0] key_q, key_prev_q;
  logic       door_q, zero_q;
  logic       key_ok, door_open, cook_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_q      <= '0;
      key_prev_q <= '0;
      door_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      key_q      <= keypad;
      key_prev_q <= key_q;
      door_q     <= door_closed;
      zero_q     <= zero;
    end
  end

  // A key counts only on the first cycle it appears after an all-zero keypad.
  assign key_ok    = (key_prev_q == 10'd0) && onehot10(key_q);
  assign door_open = ~door_q;
  assign cook_ok   = door_q & ~zero_q;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DIGIT_W-1:0] data_q, data_d;
  logic load_q, load_d, tclr_q, tclr_d;
  logic ten_q, ten_d, mag_q, mag_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    load_d  = 1'b0;
    tclr_d  = 1'b0;
    case (state_q)
      S_IDLE: if (key_ok) begin
        load_d  = 1'b1;
        data_d  = key_index(key_q);
        cnt_d   = CW'(1);
        state_d = S_ENTRY;
      end
      S_ENTRY: begin
        if (clear_p) begin
          tclr_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (stop_p) begin
          state_d = S_ENTRY;
        end else if (start_p) begin
          if (cook_ok) state_d = S_COOK;
        end else if (key_ok && cnt_q < CW'(MAX_DIGITS)) begin
          load_d = 1'b1;
          data_d = key_index(key_q);
          cnt_d  = cnt_q + CW'(1);
        end
      end
      S_COOK: begin
        if (door_open || stop_p) state_d = S_PAUSE;
        else if (zero_q)         state_d = S_DONE;
      end
      S_PAUSE: begin
        if (clear_p) begin
          tclr_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (!stop_p && start_p && cook_ok) begin
          state_d = S_COOK;
        end
      end
      S_DONE: if (door_open || clear_p || stop_p || start_p || key_ok) begin
        tclr_d  = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Drive outputs from the next state so they change with the state flop.
    ten_d  = (state_d == S_COOK);
    mag_d  = (state_d == S_COOK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      tclr_q  <= 1'b0;
      ten_q   <= 1'b0;
      mag_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      load_q  <= load_d;
      tclr_q  <= tclr_d;
      ten_q   <= ten_d;
      mag_q   <= mag_d;
      done_q  <= done_d;
    end
  end

`ifdef COOK_SEQ_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          beep_q, beep_d;

  always_comb begin
    bcnt_d = '0;
    beep_d = 1'b0;
    if (state_d == S_DONE) begin
      if (state_q != S_DONE) begin
        beep_d = 1'b1;
        bcnt_d = BW'(BEEP_CYCLES - 1);
      end else if (bcnt_q != '0) begin
        beep_d = 1'b1;
        bcnt_d = bcnt_q - BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt_q <= '0;
      beep_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      beep_q <= beep_d;
    end
  end

  assign beep = beep_q;
`endif

  assign state       = state_q;
  assign data        = data_q;
  assign load        = load_q;
  assign timer_clear = tclr_q;
  assign timer_en    = ten_q;
  assign mag_on      = mag_q;
  assign done        = done_q;
endmodule

// File: tb/tb_cook_sequencer.sv
// Directed bench for cook_sequencer; expected loads flow through a queue
// that a negedge monitor drains whenever the DUT pulses load.
module tb_cook_sequencer;
  logic       clk = 1'b0;
  logic       resetn, startn, stopn, clearn, door_closed, zero;
  logic [9:0] keypad;
  logic [3:0] data;
  logic       load, timer_clear, timer_en, mag_on, done;
  logic [2:0] state;
`ifdef COOK_SEQ_BEEP_EN
  logic       beep;
`endif

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];

  cook_sequencer #(.MAX_DIGITS(3), .BEEP_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn), .startn(startn), .stopn(stopn),
    .clearn(clearn), .door_closed(door_closed), .keypad(keypad),
    .zero(zero), .data(data), .load(load), .timer_clear(timer_clear),
    .timer_en(timer_en), .mag_on(mag_on), .done(done),
`ifdef COOK_SEQ_BEEP_EN
    .beep(beep),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key(input int k, input bit expect_load);
    keypad = 10'd1 << k;
    if (expect_load) exp_q.push_back(4'(k));
    cyc(1);
    keypad = '0;
    cyc(1);
  endtask

  task automatic press(input int which);
    if (which == 0) startn = 1'b0;
    if (which == 1) stopn  = 1'b0;
    if (which == 2) clearn = 1'b0;
    cyc(1);
    startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    cyc(1);
  endtask

  // Scoreboard drain plus invariants checked every cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (load) begin
        if (exp_q.size() == 0) chk("load_unexpected", 32'(data), 32'hFF);
        else chk("load_data", 32'(data), 32'(exp_q.pop_front()));
      end
      chk("load_tclr_excl", 32'(load & timer_clear), 0);
      chk("mag_only_cook", 32'(mag_on), 32'(state == 3'd2));
    end
  end

  initial begin
    int n;
    resetn = 1'b0; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; zero = 1'b0; keypad = '0;
    cyc(2);
    chk("rst_state", 32'(state), 0);
    chk("rst_outs", {26'd0, load, timer_clear, timer_en, mag_on, done, 1'b0}, 0);
    chk("rst_data", 32'(data), 0);
    resetn = 1'b1;
    cyc(3);
    chk("post_rst_idle", 32'(state), 0);

    // Multi-hot keypad is ignored.
    keypad = 10'b0000000011;
    cyc(1);
    keypad = '0;
    cyc(3);
    chk("multihot_idle", 32'(state), 0);

    // Keys 1,3,0 then start.
    key(1, 1); key(3, 1); key(0, 1);
    cyc(1);
    chk("entry_state", 32'(state), 1);
    chk("sb_empty_a", 32'(exp_q.size()), 0);
    startn = 1'b0;
    cyc(1);
    startn = 1'b1;
    chk("mag_not_yet", 32'(mag_on), 0);
    cyc(1);
    chk("cook_state", 32'(state), 2);
    chk("cook_mag_ten", {30'd0, mag_on, timer_en}, 3);

    // Door opens mid-cook, then resume.
    door_closed = 1'b0;
    cyc(2);
    chk("door_pause", 32'(state), 3);
    chk("door_mag_off", 32'(mag_on), 0);
    press(0);
    chk("start_door_open", 32'(state), 3);
    door_closed = 1'b1;
    cyc(2);
    press(0);
    chk("resume_cook", 32'(state), 2);

    // Timer reaches zero.
    zero = 1'b1;
    cyc(2);
    chk("done_state", 32'(state), 4);
    chk("done_flags", {30'd0, done, mag_on}, 2);
    zero = 1'b0;
`ifdef COOK_SEQ_BEEP_EN
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (beep) n++;
      cyc(1);
    end
    chk("beep_len", 32'(n), 8);
`else
    n = 0;
    cyc(3);
`endif
    chk("done_held", 32'(state), 4);
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    cyc(1);
    chk("done_clear_idle", 32'(state), 0);
    chk("done_tclr", 32'(timer_clear), 1);
    cyc(1);
    chk("tclr_one_cycle", 32'(timer_clear), 0);

    // Fourth digit is dropped.
    key(2, 1); key(4, 1); key(5, 1); key(7, 0);
    cyc(2);
    chk("sb_empty_b", 32'(exp_q.size()), 0);
    chk("four_key_entry", 32'(state), 1);
    clearn = 1'b0;
    cyc(1);
    clearn = 1'b1;
    cyc(1);
    chk("entry_clear_tclr", {30'd0, timer_clear, load}, 2);
    chk("entry_clear_idle", 32'(state), 0);

    // Clear beats start in PAUSE.
    key(1, 1);
    press(0);
    chk("cook2", 32'(state), 2);
    press(1);
    chk("stop_pause", 32'(state), 3);
    clearn = 1'b0; startn = 1'b0;
    cyc(1);
    clearn = 1'b1; startn = 1'b1;
    cyc(1);
    chk("clr_start_idle", 32'(state), 0);
    chk("clr_start_tclr", 32'(timer_clear), 1);
    cyc(3);
    chk("clr_start_mag", {29'd0, mag_on, state}, 0);

    // Asynchronous reset during cook.
    key(5, 1);
    press(0);
    chk("cook3_mag", 32'(mag_on), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_mag_off", 32'(mag_on), 0);
    chk("async_state", 32'(state), 0);
    cyc(1);
    resetn = 1'b1;
    cyc(3);
    chk("post_async_idle", 32'(state), 0);

    // A held key loads once.
    keypad = 10'd1 << 6;
    exp_q.push_back(4'd6);
    cyc(5);
    keypad = '0;
    cyc(2);
    chk("held_key_entry", 32'(state), 1);
    chk("sb_empty_c", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
